// File: rtl/simple_proc_ctrl_if.sv
// Bus bundle between simple_proc_ctrl and its neighbours.
// Members:
//   imem_*  : instruction fetch handshake (req/ack, addr, 24-bit rdata)
//   rf_*    : register-file read addresses/data and write strobe/address/data
//   alu_*   : ALU opcode, operands, immediate, condition gate, result and NZCV flags
//   mem_*   : data-memory handshake (req/ack, we, addr, wdata, rdata)
// Modports:
//   master : the sequencer (drives requests, addresses, ALU controls)
//   slave  : the environment (memories, register file, ALU)
interface simple_proc_ctrl_if #(
  parameter int PC_W = 8
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [23:0]     imem_rdata;

  logic [2:0]      rf_raddr1;
  logic [2:0]      rf_raddr2;
  logic [15:0]     rf_rdata1;
  logic [15:0]     rf_rdata2;
  logic            rf_we;
  logic [2:0]      rf_waddr;
  logic [15:0]     rf_wdata;

  logic [3:0]      alu_opcode;
  logic [15:0]     alu_op1;
  logic [15:0]     alu_op2;
  logic [6:0]      alu_imm;
  logic            alu_cond_ok;
  logic [15:0]     alu_result;
  logic            alu_n;
  logic            alu_z;
  logic            alu_c;
  logic            alu_v;

  logic            mem_req;
  logic            mem_we;
  logic [15:0]     mem_addr;
  logic [15:0]     mem_wdata;
  logic [15:0]     mem_rdata;
  logic            mem_ack;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata,
    input  rf_rdata1, rf_rdata2,
    output alu_opcode, alu_op1, alu_op2, alu_imm, alu_cond_ok,
    input  alu_result, alu_n, alu_z, alu_c, alu_v,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata,
    output rf_rdata1, rf_rdata2,
    input  alu_opcode, alu_op1, alu_op2, alu_imm, alu_cond_ok,
    output alu_result, alu_n, alu_z, alu_c, alu_v,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/simple_proc_ctrl.sv
// Multi-cycle sequencer for simple_proc_alu.
// Fetches a 24-bit instruction, reads two registers, evaluates the condition
// code against the ALU's registered NZCV flags, drives the ALU for one cycle
// and writes the result back. LDR (op D) and STR (op E) use the data-memory
// req/ack port instead of the ALU result.
// Instruction: [23:20] cond [19:16] op [15:13] rd [12:10] rs1 [9:7] rs2 [6:0] imm
// Ports:
//   clk     : clock
//   rst_n   : asynchronous active-low reset
//   i_run   : 1 = keep sequencing; sampled in IDLE and when an instruction retires
//   o_busy  : 1 in every state except IDLE
//   bus     : simple_proc_ctrl_if.master (imem, register file, ALU, dmem)
module simple_proc_ctrl #(
  parameter int PC_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_run,
  output logic                o_busy,
  simple_proc_ctrl_if.master  bus
);

  localparam logic [3:0] OP_CMP = 4'hB;
  localparam logic [3:0] OP_LDR = 4'hD;
  localparam logic [3:0] OP_STR = 4'hE;
  localparam logic [3:0] OP_NOP = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_MEM
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [PC_W-1:0] r_pc;
  logic [23:0]     r_instr;
  logic [15:0]     r_op1;
  logic [15:0]     r_op2;
  logic            r_cond_ok;

  logic [3:0]      w_cond;
  logic [3:0]      w_op;
  logic [6:0]      w_imm;
  logic            w_cond_ok;
  logic            w_is_mem;
  logic            w_writes;
  logic            w_retire;

  function automatic logic cond_check(input logic [3:0] cc, input logic nf,
                                      input logic zf, input logic cf, input logic vf);
    logic res;
    unique case (cc)
      4'h0: res = zf;
      4'h1: res = !zf;
      4'h2: res = cf;
      4'h3: res = !cf;
      4'h4: res = nf;
      4'h5: res = !nf;
      4'h6: res = vf;
      4'h7: res = !vf;
      4'h8: res = cf && !zf;
      4'h9: res = !cf || zf;
      4'hA: res = (nf == vf);
      4'hB: res = (nf != vf);
      4'hC: res = !zf && (nf == vf);
      4'hD: res = zf || (nf != vf);
      4'hE: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  assign w_cond    = r_instr[23:20];
  assign w_op      = r_instr[19:16];
  assign w_imm     = r_instr[6:0];
  assign w_cond_ok = cond_check(w_cond, bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v);
  assign w_is_mem  = (w_op == OP_LDR) || (w_op == OP_STR);
  // Ops 0..A and C produce a register result; CMP only sets flags.
  assign w_writes  = (w_op != OP_CMP) && (w_op != OP_LDR) && (w_op != OP_STR) && (w_op != OP_NOP);
  // An instruction retires when WB is left or the memory access completes.
  assign w_retire  = (r_state == S_WB) || ((r_state == S_MEM) && bus.mem_ack);

  assign bus.imem_addr = r_pc;
  assign bus.rf_raddr1 = r_instr[12:10];
  assign bus.rf_raddr2 = r_instr[9:7];
  assign bus.rf_waddr  = r_instr[15:13];
  assign bus.alu_op1   = r_op1;
  assign bus.alu_op2   = r_op2;
  assign bus.alu_imm   = w_imm;
  assign bus.mem_addr  = r_op1 + {9'd0, w_imm};
  assign bus.mem_wdata = r_op2;

  // State register: async reset drops every request output immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= '0;
      r_instr   <= '0;
      r_op1     <= '0;
      r_op2     <= '0;
      r_cond_ok <= 1'b0;
    end else begin
      if (w_retire)
        r_pc <= r_pc + {{(PC_W-1){1'b0}}, 1'b1};
      if ((r_state == S_FETCH) && bus.imem_ack)
        r_instr <= bus.imem_rdata;
      if (r_state == S_DECODE) begin
        r_op1 <= bus.rf_rdata1;
        r_op2 <= bus.rf_rdata2;
      end
      // Flags change at the end of EXEC, so the decision is kept for WB.
      if (r_state == S_EXEC)
        r_cond_ok <= w_cond_ok;
    end
  end

  always_comb begin
    w_next          = r_state;
    o_busy          = 1'b1;
    bus.imem_req    = 1'b0;
    bus.mem_req     = 1'b0;
    bus.mem_we      = 1'b0;
    bus.rf_we       = 1'b0;
    bus.rf_wdata    = '0;
    bus.alu_opcode  = OP_NOP;
    bus.alu_cond_ok = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_run) w_next = S_FETCH;
      end
      S_FETCH: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ack) w_next = S_DECODE;
      end
      S_DECODE: begin
        w_next = S_EXEC;
      end
      S_EXEC: begin
        bus.alu_opcode  = w_op;
        bus.alu_cond_ok = w_cond_ok;
        // Memory ops with a failed condition take the WB path and write nothing.
        w_next = (w_cond_ok && w_is_mem) ? S_MEM : S_WB;
      end
      S_WB: begin
        bus.rf_we    = r_cond_ok && w_writes;
        bus.rf_wdata = bus.alu_result;
        w_next       = i_run ? S_FETCH : S_IDLE;
      end
      S_MEM: begin
        bus.mem_req  = 1'b1;
        bus.mem_we   = (w_op == OP_STR);
        bus.rf_wdata = bus.mem_rdata;
        if (bus.mem_ack) begin
          bus.rf_we = (w_op == OP_LDR);
          w_next    = i_run ? S_FETCH : S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule
